// File: rtl/msg_uart_tx_pkg.sv
// Shared definitions for the message UART transmitter: FSM states and line constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package msg_uart_tx_pkg;

  // Transmit FSM states, in frame order.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  // 100 MHz core clock, 115200 baud.
  localparam int DEF_CLKS_PER_BIT = 868;

  // Mark level of an idle async serial line.
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/msg_uart_tx_baud_tick.sv
// Reloadable bit-period down-counter; flags the last cycle of every serial bit.
// Latency: o_tick is high CLKS_PER_BIT-1 cycles after a restart, then every CLKS_PER_BIT cycles.
// Backpressure: none; free-running between restarts.
module uart_baud_tick
  import msg_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick,
  output logic o_pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Count down one bit period; reload on restart or when the period expires so bits never drift.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // o_pre_tick lets the parent register a strobe that lands exactly on the tick cycle.
  assign o_tick     = (r_cnt == '0);
  assign o_pre_tick = (r_cnt == CW'(1));

endmodule

// File: rtl/msg_uart_tx.sv
// Drains the byte TX FIFO and serialises each byte: start, 8 data LSB first, optional parity, 1-2 stops.
// Latency: RD one cycle after EMPTY is seen low in IDLE; start bit two cycles after RD.
// Backpressure: FIFO is read only from IDLE, one byte per frame, never while EMPTY is high.
module msg_uart_tx
  import msg_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic       OPB_CLK,
  input  logic       OPB_RST,
  input  logic       TX_FIFO_EMPTY,
  output logic       TX_FIFO_RD,
  input  logic [7:0] TX_FIFO_DATA,
  output logic       UART_TXD,
  output logic       TX_BUSY,
  output logic       TX_BYTE_DONE
);

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;
  logic       r_parity;
  logic       w_parity_nxt;
  logic [2:0] r_bit_idx;
  logic [2:0] w_bit_idx_nxt;
  logic       r_rd;
  logic       r_txd;
  logic       r_busy;
  logic       r_done;
  logic       w_rd_nxt;
  logic       w_txd_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_tick;
  logic       w_pre_tick;
  logic       w_restart;
  logic       w_last_stop;

  // Every state change restarts the bit period; bit boundaries reload inside the counter.
  assign w_restart   = (w_state_nxt != r_state);
  assign w_last_stop = (r_bit_idx == LAST_STOP);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .i_clk      (OPB_CLK),
    .i_rst      (OPB_RST),
    .i_restart  (w_restart),
    .o_tick     (w_tick),
    .o_pre_tick (w_pre_tick)
  );

  // FSM state register.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, shift register, parity and bit index.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_bit_idx_nxt = r_bit_idx;
    case (r_state)
      S_IDLE: begin
        // r_rd high means this IDLE cycle is the read strobe; data arrives next cycle.
        if (r_rd) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_shift_nxt  = TX_FIFO_DATA;
        w_parity_nxt = (^TX_FIFO_DATA) ^ PARITY_ODD;
        w_state_nxt  = S_START;
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_nxt   = S_STOP;
          w_bit_idx_nxt = '0;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_last_stop) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output values for the next cycle, decoded from the next state so every pin is a flop.
  always_comb begin
    w_rd_nxt   = (w_state_nxt == S_IDLE) && !TX_FIFO_EMPTY;
    w_busy_nxt = (w_state_nxt != S_IDLE) || w_rd_nxt;
    w_done_nxt = (r_state == S_STOP) && w_last_stop && w_pre_tick;
    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shift_nxt[0];
      S_PARITY: w_txd_nxt = w_parity_nxt;
      default:  w_txd_nxt = LINE_IDLE;
    endcase
  end

  // Datapath and registered outputs; reset drops any frame in flight and returns the line to mark.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit_idx <= '0;
      r_rd      <= 1'b0;
      r_txd     <= LINE_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_rd      <= w_rd_nxt;
      r_txd     <= w_txd_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign TX_FIFO_RD   = r_rd;
  assign UART_TXD     = r_txd;
  assign TX_BUSY      = r_busy;
  assign TX_BYTE_DONE = r_done;

endmodule

// File: tb/tb_msg_uart_tx.sv
// Bench for msg_uart_tx: four instances (no parity, even, odd, two stops) against a timeline model.
// Latency: n/a.
// Backpressure: FIFO model with one-cycle read latency per instance.
module tb_msg_uart_tx;

  localparam int CPB  = 4;
  localparam int NI   = 4;
  localparam int CAPW = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       fempty [NI] = '{default: 1'b1};
  logic [7:0] fdat   [NI] = '{default: 8'h00};
  logic       rd     [NI];
  logic       txd    [NI];
  logic       busy   [NI];
  logic       done   [NI];
  logic [7:0] fmem   [NI][16];
  int         wp     [NI] = '{default: 0};
  int         rp     [NI] = '{default: 0};
  int         rd_empty_err = 0;

  int n_pass  = 0;
  int n_total = 0;

  logic [CAPW-1:0] c_txd, c_rd, c_busy, c_done;

  always #5 clk = ~clk;

  msg_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut0 (
    .OPB_CLK(clk), .OPB_RST(rst), .TX_FIFO_EMPTY(fempty[0]), .TX_FIFO_RD(rd[0]),
    .TX_FIFO_DATA(fdat[0]), .UART_TXD(txd[0]), .TX_BUSY(busy[0]), .TX_BYTE_DONE(done[0]));
  msg_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut1 (
    .OPB_CLK(clk), .OPB_RST(rst), .TX_FIFO_EMPTY(fempty[1]), .TX_FIFO_RD(rd[1]),
    .TX_FIFO_DATA(fdat[1]), .UART_TXD(txd[1]), .TX_BUSY(busy[1]), .TX_BYTE_DONE(done[1]));
  msg_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_dut2 (
    .OPB_CLK(clk), .OPB_RST(rst), .TX_FIFO_EMPTY(fempty[2]), .TX_FIFO_RD(rd[2]),
    .TX_FIFO_DATA(fdat[2]), .UART_TXD(txd[2]), .TX_BUSY(busy[2]), .TX_BYTE_DONE(done[2]));
  msg_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_dut3 (
    .OPB_CLK(clk), .OPB_RST(rst), .TX_FIFO_EMPTY(fempty[3]), .TX_FIFO_RD(rd[3]),
    .TX_FIFO_DATA(fdat[3]), .UART_TXD(txd[3]), .TX_BUSY(busy[3]), .TX_BYTE_DONE(done[3]));

  // FIFO model: a read strobe seen on an edge presents the head byte for the following cycle.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rd[i] === 1'b1) begin
        if (wp[i] == rp[i]) rd_empty_err <= rd_empty_err + 1;
        fdat[i]   <= fmem[i][rp[i] % 16];
        rp[i]     <= rp[i] + 1;
        fempty[i] <= (wp[i] == rp[i] + 1);
      end else begin
        fempty[i] <= (wp[i] == rp[i]);
      end
    end
  end

  function automatic int pen(input int inst);
    return (inst == 1 || inst == 2) ? 1 : 0;
  endfunction

  function automatic int nstop(input int inst);
    return (inst == 3) ? 2 : 1;
  endfunction

  // Parity bit from a plain count of ones: even parity makes the total even, odd makes it odd.
  function automatic logic par_bit(input logic [7:0] b, input int inst);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return (inst == 2) ? logic'((ones + 1) % 2) : logic'(ones % 2);
  endfunction

  // Line level during serial bit number bit_no of a frame carrying byte b.
  function automatic logic level(input logic [7:0] b, input int bit_no, input int inst);
    if (bit_no == 0) return 1'b0;
    if (bit_no <= 8) return b[bit_no-1];
    if (pen(inst) == 1 && bit_no == 9) return par_bit(b, inst);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [CAPW-1:0] obs, input logic [CAPW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input int inst, input logic [7:0] b);
    fmem[inst][wp[inst] % 16] = b;
    wp[inst] = wp[inst] + 1;
  endtask

  task automatic capture(input int inst, input int n);
    c_txd = '0; c_rd = '0; c_busy = '0; c_done = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c_txd[i]  = txd[inst];
      c_rd[i]   = rd[inst];
      c_busy[i] = busy[inst];
      c_done[i] = done[inst];
    end
  endtask

  // Push nb bytes at once, capture the line and compare against a cycle timeline of the frames.
  task automatic run_frames(input int inst, input int nb, input logic [7:0] b0,
                            input logic [7:0] b1, input string tag);
    int len, n, rdk, st, en;
    logic [7:0] bk, dec;
    logic [CAPW-1:0] e_txd, e_rd, e_busy, e_done;
    len = (1 + 8 + pen(inst) + nstop(inst)) * CPB;
    n   = 1 + nb * (len + 3) + 8;
    @(negedge clk);
    push(inst, b0);
    if (nb > 1) push(inst, b1);
    capture(inst, n);
    e_txd = '0; e_rd = '0; e_busy = '0; e_done = '0;
    for (int c = 0; c < n; c++) e_txd[c] = 1'b1;
    rdk = 1;
    for (int k = 0; k < nb; k++) begin
      bk = (k == 0) ? b0 : b1;
      st = rdk + 2;
      en = st + len - 1;
      e_rd[rdk] = 1'b1;
      e_done[en] = 1'b1;
      for (int c = rdk; c <= en; c++) e_busy[c] = 1'b1;
      for (int t = 0; t < len; t++) e_txd[st+t] = level(bk, t / CPB, inst);
      for (int i = 0; i < 8; i++) dec[i] = c_txd[st + CPB*(1+i) + CPB/2];
      chk({tag, "_byte"}, CAPW'(dec), CAPW'(bk));
      if (pen(inst) == 1)
        chk({tag, "_parity"}, CAPW'(c_txd[st + 9*CPB + CPB/2]), CAPW'(par_bit(bk, inst)));
      rdk = en + 1;
    end
    chk({tag, "_rd_count"}, CAPW'($countones(c_rd)), CAPW'(nb));
    chk({tag, "_txd"}, c_txd, e_txd);
    chk({tag, "_rd"}, c_rd, e_rd);
    chk({tag, "_busy"}, c_busy, e_busy);
    chk({tag, "_done"}, c_done, e_done);
  endtask

  initial begin
    logic acc;
    logic [7:0] rb0, rb1;
    int ri;

    // Reset held three cycles with every FIFO empty.
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_txd",  CAPW'({txd[3], txd[2], txd[1], txd[0]}), CAPW'(4'hF));
      chk("rst_busy", CAPW'({busy[3], busy[2], busy[1], busy[0]}), CAPW'(4'h0));
      chk("rst_rd",   CAPW'({rd[3], rd[2], rd[1], rd[0]}), CAPW'(4'h0));
      chk("rst_done", CAPW'({done[3], done[2], done[1], done[0]}), CAPW'(4'h0));
    end
    rst = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc = acc | rd[0] | rd[1] | rd[2] | rd[3] | !txd[0] | !txd[1] | !txd[2] | !txd[3];
    end
    chk("idle_quiet", CAPW'(acc), CAPW'(1'b0));

    // Directed frames.
    run_frames(0, 1, 8'h55, 8'h00, "t2_55");
    run_frames(0, 2, 8'hA3, 8'h0F, "t3_b2b");
    run_frames(1, 1, 8'h07, 8'h00, "t4_even");
    run_frames(2, 1, 8'h07, 8'h00, "t4_odd");
    run_frames(3, 1, 8'hFF, 8'h00, "t5_stop2");

    // Randomised bytes on random instances, single and back-to-back.
    for (int r = 0; r < 8; r++) begin
      ri  = int'($urandom_range(0, NI - 1));
      rb0 = 8'($urandom);
      rb1 = 8'($urandom);
      run_frames(ri, int'($urandom_range(1, 2)), rb0, rb1, "rnd");
    end

    // Reset in the middle of data bit 3 of 0x81.
    @(negedge clk);
    push(0, 8'h81);
    repeat (21) @(negedge clk);
    chk("t6_bit3_txd", CAPW'(txd[0]), CAPW'(1'b0));
    chk("t6_bit3_busy", CAPW'(busy[0]), CAPW'(1'b1));
    #2 rst = 1'b1;
    #1;
    chk("t6_async_txd", CAPW'(txd[0]), CAPW'(1'b1));
    chk("t6_async_busy", CAPW'(busy[0]), CAPW'(1'b0));
    acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      acc = acc | done[0] | !txd[0];
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      acc = acc | done[0] | !txd[0] | rd[0];
    end
    chk("t6_no_done", CAPW'(acc), CAPW'(1'b0));
    rb0 = 8'($urandom);
    run_frames(0, 1, rb0, 8'h00, "t6_post");

    chk("rd_while_empty", CAPW'(rd_empty_err), CAPW'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
